// File: rtl/alu_lfsr_sequencer_if.sv
// Output stream and shared-ALU bus of the LFSR sequencer.
// The master side belongs to the sequencer; the slave side holds the ALU and the stream sink.
interface alu_lfsr_sequencer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] alu_opcode;
  logic [7:0] alu_in_a;
  logic [7:0] alu_in_b;
  logic       alu_rdx;
  logic       alu_shift;
  logic [7:0] alu_out;

  modport master (
    output out_data, out_valid,
    input  out_ready,
    output alu_opcode, alu_in_a, alu_in_b, alu_rdx, alu_shift,
    input  alu_out
  );

  modport slave (
    input  out_data, out_valid,
    output out_ready,
    input  alu_opcode, alu_in_a, alu_in_b, alu_rdx, alu_shift,
    output alu_out
  );
endinterface

// File: rtl/alu_lfsr_sequencer.sv
// Drives the shared combinational ALU through two cycles per step (parity, then shift)
// to advance a Fibonacci LFSR, emitting each new state on a valid/ready stream.
module alu_lfsr_sequencer #(
  parameter int         CNT_W     = 8,
  parameter logic [2:0] OP_LSHIFT = 3'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        seed,
  input  logic [7:0]        taps,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  alu_lfsr_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PARITY = 3'd1,
    S_SHIFT  = 3'd2,
    S_EMIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_reg;
  state_t           state_next;
  logic [7:0]       lfsr_reg;
  logic [7:0]       tap_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fb_reg;

  // State register plus the datapath registers it sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      lfsr_reg  <= 8'h00;
      tap_reg   <= 8'h00;
      cnt_reg   <= CNT_ZERO;
      fb_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            lfsr_reg <= seed;
            tap_reg  <= taps;
            cnt_reg  <= count;
          end
        end
        S_PARITY: fb_reg <= bus.alu_out[0];
        // The ALU shift drops the old MSB; the feedback bit fills the LSB.
        S_SHIFT:  lfsr_reg <= {bus.alu_out[7:1], fb_reg};
        S_EMIT: begin
          if (bus.out_ready) cnt_reg <= cnt_reg - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = (count == CNT_ZERO) ? S_DONE : S_PARITY;
      end
      S_PARITY: state_next = S_SHIFT;
      S_SHIFT:  state_next = S_EMIT;
      S_EMIT: begin
        if (bus.out_ready) state_next = (cnt_reg == CNT_ONE) ? S_DONE : S_PARITY;
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only, so out_valid never sees out_ready.
  always_comb begin
    busy           = (state_reg != S_IDLE);
    done           = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_data   = 8'h00;
    bus.alu_opcode = 3'd0;
    bus.alu_in_a   = 8'h00;
    bus.alu_in_b   = 8'h00;
    bus.alu_rdx    = 1'b0;
    bus.alu_shift  = 1'b0;
    case (state_reg)
      S_PARITY: begin
        bus.alu_opcode = OP_LSHIFT;
        bus.alu_rdx    = 1'b1;
        bus.alu_in_a   = lfsr_reg;
        bus.alu_in_b   = lfsr_reg & tap_reg;
      end
      S_SHIFT: begin
        bus.alu_opcode = OP_LSHIFT;
        bus.alu_in_a   = lfsr_reg;
        bus.alu_in_b   = 8'h01;
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = lfsr_reg;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_lfsr_sequencer.sv
// Directed bench: a table of LFSR runs with hand-computed outputs and timing,
// plus an asynchronous reset abort sequence.
module tb_alu_lfsr_sequencer;

  localparam logic [2:0] OP_LSHIFT = 3'd4;

  typedef struct {
    logic [7:0]      seed;
    logic [7:0]      taps;
    int              count;
    int              stall;
    int              sp1;
    int              sp2;
    logic [3:0][7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] taps = 8'h00;
  logic [7:0] count = 8'h00;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  alu_lfsr_sequencer_if bus();

  alu_lfsr_sequencer #(.CNT_W(8), .OP_LSHIFT(OP_LSHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .seed  (seed),
    .taps  (taps),
    .count (count),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: LSHIFT with rdx=1 gives parity of B in bit 0, rdx=0 gives A << B.
  always_comb begin
    bus.alu_out = 8'h00;
    if (bus.alu_opcode == OP_LSHIFT)
      bus.alu_out = bus.alu_rdx ? {7'b0, ^bus.alu_in_b} : (bus.alu_in_a << bus.alu_in_b[2:0]);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] s, input logic [7:0] t, input int n,
                              input int stall, input int sp1, input int sp2,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    vec_t v;
    v.seed  = s;
    v.taps  = t;
    v.count = n;
    v.stall = stall;
    v.sp1   = sp1;
    v.sp2   = sp2;
    v.exp   = {e3, e2, e1, e0};
    return v;
  endfunction

  // k counts rising edges after the cycle in which start is driven.
  task automatic run(input int idx, input vec_t v);
    logic [7:0] ed[$];
    int         et[$];
    int         dt[$];
    int         busy_n;
    int         busy_fall;
    int         stall_left;
    int         limit;
    int         n_chk;
    busy_n     = 0;
    busy_fall  = -1;
    stall_left = v.stall;
    limit      = 3 * v.count + v.stall + 4;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    seed  = v.seed;
    taps  = v.taps;
    count = 8'(v.count);
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      start = (k == v.sp1) || (k == v.sp2);
      seed  = 8'hFF;
      taps  = 8'hFF;
      count = 8'd7;
      if (bus.out_valid && stall_left > 0) begin
        stall_left--;
        bus.out_ready = 1'b0;
        chk("stall_hold_data", 32'(bus.out_data), 32'(v.exp[0]));
      end else begin
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        ed.push_back(bus.out_data);
        et.push_back(k);
      end
      if (done) dt.push_back(k);
      if (busy) busy_n++;
      else if (busy_fall < 0 && busy_n > 0) busy_fall = k;
      if (k == 1 && v.count != 0) begin
        chk("parity_opcode", 32'(bus.alu_opcode), 32'(OP_LSHIFT));
        chk("parity_rdx", 32'(bus.alu_rdx), 1);
        chk("parity_in_b", 32'(bus.alu_in_b), 32'(v.seed & v.taps));
      end
      if (k == 2 && v.count != 0) begin
        chk("shift_rdx", 32'(bus.alu_rdx), 0);
        chk("shift_in_a", 32'(bus.alu_in_a), 32'(v.seed));
        chk("shift_in_b", 32'(bus.alu_in_b), 1);
      end
    end
    start = 1'b0;
    chk("emit_count", ed.size(), v.count);
    n_chk = (ed.size() < v.count) ? ed.size() : v.count;
    for (int i = 0; i < n_chk; i++) begin
      chk("emit_data", 32'(ed[i]), 32'(v.exp[(i < 4) ? i : 3]));
      chk("emit_cycle", et[i], 3 * (i + 1) + v.stall);
    end
    chk("done_pulses", dt.size(), 1);
    if (dt.size() > 0) chk("done_cycle", dt[0], 3 * v.count + 1 + v.stall);
    chk("busy_fall_cycle", busy_fall, 3 * v.count + 2 + v.stall);
    chk("busy_cycles", busy_n, 3 * v.count + 1 + v.stall);
    $display("[TB] vec %0d seed=%02h taps=%02h count=%0d stall=%0d emitted=%0d",
             idx, v.seed, v.taps, v.count, v.stall, ed.size());
  endtask

  vec_t vecs[9];

  initial begin
    //           seed   taps   n    stall sp1 sp2  e0     e1     e2     e3
    vecs[0] = mk(8'h80, 8'hB8, 3,   0,   -1, -1,  8'h01, 8'h02, 8'h04, 8'h00);
    vecs[1] = mk(8'hB8, 8'hB8, 2,   0,   -1, -1,  8'h70, 8'hE0, 8'h00, 8'h00);
    vecs[2] = mk(8'h80, 8'hB8, 3,   5,   -1, -1,  8'h01, 8'h02, 8'h04, 8'h00);
    vecs[3] = mk(8'h5A, 8'hB8, 0,   0,   -1, -1,  8'h00, 8'h00, 8'h00, 8'h00);
    vecs[4] = mk(8'h80, 8'hB8, 3,   0,    5, 10,  8'h01, 8'h02, 8'h04, 8'h00);
    vecs[5] = mk(8'h00, 8'hFF, 2,   0,   -1, -1,  8'h00, 8'h00, 8'h00, 8'h00);
    vecs[6] = mk(8'hC3, 8'h00, 2,   0,   -1, -1,  8'h86, 8'h0C, 8'h00, 8'h00);
    vecs[7] = mk(8'h01, 8'h03, 3,   0,   -1, -1,  8'h03, 8'h06, 8'h0D, 8'h00);
    vecs[8] = mk(8'h00, 8'hB8, 255, 0,   -1, -1,  8'h00, 8'h00, 8'h00, 8'h00);

    bus.out_ready = 1'b1;
    #12;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_data", 32'(bus.out_data), 0);
    chk("reset_alu_opcode", 32'(bus.alu_opcode), 0);
    chk("reset_alu_in_a", 32'(bus.alu_in_a), 0);
    chk("reset_alu_shift", 32'(bus.alu_shift), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run(i, vecs[i]);

    // Asynchronous reset while the first state waits in EMIT under backpressure.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    start = 1'b1;
    seed  = 8'h80;
    taps  = 8'hB8;
    count = 8'd3;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("abort_pre_valid", 32'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_data", 32'(bus.out_data), 0);
    chk("abort_alu_opcode", 32'(bus.alu_opcode), 0);
    chk("abort_alu_in_a", 32'(bus.alu_in_a), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_done", 32'(done), 0);
    chk("abort_idle_busy", 32'(busy), 0);
    $display("[TB] async reset abort sequence complete");
    run(9, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
